// File: rtl/csr_encoder.sv
// Streams a dense row-major matrix in and builds its CSR form (NV/CI/RP).
// Capacity is one less than the array depth, so every row pointer fits the index width.
module csr_encoder #(
  parameter int data_width_param   = 32,
  parameter int max_elements_param = 16,
  parameter int idx_width_param    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [idx_width_param-1:0]  rows_i,
  input  logic [idx_width_param-1:0]  cols_i,
  input  logic                        elem_valid_i,
  input  logic [data_width_param-1:0] elem_data_i,
  output logic                        elem_ready_o,
  output logic [data_width_param-1:0] NV_o [max_elements_param],
  output logic [idx_width_param-1:0]  CI_o [max_elements_param],
  output logic [idx_width_param-1:0]  RP_o [max_elements_param],
  output logic [idx_width_param-1:0]  nnz_o,
  output logic [idx_width_param-1:0]  rows_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overflow_o
);

  localparam logic [idx_width_param-1:0] one = idx_width_param'(1);
  localparam logic [idx_width_param-1:0] cap = idx_width_param'(max_elements_param - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                       state_q, state_d;
  logic [idx_width_param-1:0]   cols_q, row_q, col_q, nnz_next;
  logic                         start_ok, zero_dim, accept, nonzero, store;
  logic                         last_col, last_elem;

  assign start_ok  = start_i && (state_q != LOAD);
  assign zero_dim  = (rows_i == '0) || (cols_i == '0);
  assign accept    = elem_valid_i && (state_q == LOAD);
  assign nonzero   = (elem_data_i != '0);
  assign store     = accept && nonzero && (nnz_o < cap);
  assign nnz_next  = store ? nnz_o + one : nnz_o;
  assign last_col  = (col_q == cols_q - one);
  assign last_elem = last_col && (row_q == rows_o - one);

  assign elem_ready_o = (state_q == LOAD);
  assign busy_o       = elem_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d takes its hold value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_i) state_d = zero_dim ? DONE : LOAD;
      LOAD:       if (accept && last_elem) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: the arrays are real outputs that must read zero straight out of reset,
  // so they sit on the async reset like any other register rather than as an unreset RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < max_elements_param; i++) begin
        NV_o[i] <= '0;
        CI_o[i] <= '0;
        RP_o[i] <= '0;
      end
      nnz_o      <= '0;
      rows_o     <= '0;
      cols_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_ok) begin
        for (int i = 0; i < max_elements_param; i++) begin
          NV_o[i] <= '0;
          CI_o[i] <= '0;
          RP_o[i] <= '0;
        end
        nnz_o      <= '0;
        overflow_o <= 1'b0;
        rows_o     <= rows_i;
        cols_q     <= cols_i;
        row_q      <= '0;
        col_q      <= '0;
        done_o     <= zero_dim;
      end else if (accept) begin
        if (store) begin
          NV_o[nnz_o] <= elem_data_i;
          CI_o[nnz_o] <= col_q;
          nnz_o       <= nnz_next;
        end else if (nonzero) begin
          overflow_o  <= 1'b1;
        end
        // Row pointer records the count including the element that closes the row.
        if (last_col) begin
          RP_o[row_q + one] <= nnz_next;
          col_q             <= '0;
          row_q             <= row_q + one;
        end else begin
          col_q <= col_q + one;
        end
        if (last_elem) done_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_encoder.sv
// Directed bench for csr_encoder: dense/toggled handshakes, all-zero, overflow,
// zero dimension, start during done pulse, and asynchronous reset mid-load.
module tb_csr_encoder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  rows_i = '0;
  logic [3:0]  cols_i = '0;
  logic        elem_valid_i = 1'b0;
  logic [31:0] elem_data_i = '0;
  logic        elem_ready_o, busy_o, done_o, overflow_o;
  logic [31:0] nv [16];
  logic [3:0]  ci [16];
  logic [3:0]  rp [16];
  logic [3:0]  nnz_o, rows_o;

  int errors = 0;
  int checks = 0;

  int mat    [16];
  int exp_nv [16];
  int exp_ci [16];
  int exp_rp [16];

  csr_encoder dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .rows_i       (rows_i),
    .cols_i       (cols_i),
    .elem_valid_i (elem_valid_i),
    .elem_data_i  (elem_data_i),
    .elem_ready_o (elem_ready_o),
    .NV_o         (nv),
    .CI_o         (ci),
    .RP_o         (rp),
    .nnz_o        (nnz_o),
    .rows_o       (rows_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_arrays(input string tag);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_nv%0d", tag, i), nv[i], exp_nv[i]);
      check($sformatf("%s_ci%0d", tag, i), {28'd0, ci[i]}, exp_ci[i]);
      check($sformatf("%s_rp%0d", tag, i), {28'd0, rp[i]}, exp_rp[i]);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"}, elem_ready_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_ovf"}, overflow_o, 0);
    check({tag, "_nnz"}, nnz_o, 0);
    check({tag, "_rows"}, rows_o, 0);
    exp_nv = '{default: 0};
    exp_ci = '{default: 0};
    exp_rp = '{default: 0};
    check_arrays(tag);
  endtask

  // Start on the next edge; returns #1 after that edge with start_i released.
  task automatic do_start(input logic [3:0] r, input logic [3:0] c);
    @(negedge clk_i);
    start_i = 1'b1;
    rows_i  = r;
    cols_i  = c;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Presents mat[0..n-1]; returns at the negedge that sets up the n-th handshake.
  task automatic feed(input string tag, input int n, input bit toggle);
    int  i = 0;
    int  guard = 0;
    bit  v = 1'b0;
    while (i < n && guard < 200) begin
      @(negedge clk_i);
      check({tag, "_no_early_done"}, done_o, 0);
      v = toggle ? ~v : 1'b1;
      elem_valid_i = v;
      elem_data_i  = mat[i];
      if (v && elem_ready_o) i++;
      guard++;
    end
    check({tag, "_handshakes"}, i, n);
  endtask

  // Completes the final handshake and checks the one-cycle done pulse.
  task automatic finish_feed(input string tag);
    @(posedge clk_i);
    #1;
    elem_valid_i = 1'b0;
    check({tag, "_done_pulse"}, done_o, 1);
    check({tag, "_ready_off"}, elem_ready_o, 0);
  endtask

  task automatic load_case1();
    mat    = '{0,0,1,0, 0,5,7,0, 9,0,0,4, 2,6,0,0};
    exp_nv = '{1,5,7,9,4,2,6,0,0,0,0,0,0,0,0,0};
    exp_ci = '{2,1,2,0,3,0,1,0,0,0,0,0,0,0,0,0};
    exp_rp = '{0,1,3,5,7,0,0,0,0,0,0,0,0,0,0,0};
  endtask

  initial begin
    // Reset state
    #1;
    check_idle_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("idle_wait_ready", elem_ready_o, 0);

    // 4x4 dense, valid held high
    load_case1();
    do_start(4, 4);
    check("c1_load_ready", elem_ready_o, 1);
    check("c1_load_busy", busy_o, 1);
    check("c1_rows", rows_o, 4);
    feed("c1", 16, 1'b0);
    finish_feed("c1");
    check("c1_nnz", nnz_o, 7);
    check("c1_ovf", overflow_o, 0);
    check_arrays("c1");
    @(posedge clk_i);
    #1;
    check("c1_done_clear", done_o, 0);
    check("c1_hold_nnz", nnz_o, 7);
    check("c1_hold_busy", busy_o, 0);

    // Same matrix, valid toggling
    do_start(4, 4);
    check("c2_cleared_nnz", nnz_o, 0);
    check("c2_cleared_nv0", nv[0], 0);
    feed("c2", 16, 1'b1);
    finish_feed("c2");
    check("c2_nnz", nnz_o, 7);
    check_arrays("c2");

    // 3x5 all-zero
    mat = '{default: 0};
    do_start(3, 5);
    feed("c3", 15, 1'b0);
    finish_feed("c3");
    check("c3_nnz", nnz_o, 0);
    check("c3_ovf", overflow_o, 0);
    check("c3_rows", rows_o, 3);
    exp_nv = '{default: 0};
    exp_ci = '{default: 0};
    exp_rp = '{default: 0};
    check_arrays("c3");

    // Zero-row start issued during the done pulse
    do_start(0, 4);
    check("zd_done", done_o, 1);
    check("zd_rows", rows_o, 0);
    check("zd_ready", elem_ready_o, 0);
    @(posedge clk_i);
    #1;
    check("zd_done_clear", done_o, 0);
    check("zd_ready_after", elem_ready_o, 0);

    // 4x4 values 1..16: capacity exceeded on the last one
    for (int k = 0; k < 16; k++) mat[k] = k + 1;
    exp_nv = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,0};
    exp_ci = '{0,1,2,3,0,1,2,3,0,1,2,3,0,1,2,0};
    exp_rp = '{0,4,8,12,15,0,0,0,0,0,0,0,0,0,0,0};
    do_start(4, 4);
    feed("c4", 15, 1'b0);
    @(posedge clk_i);
    #1;
    check("c4_no_ovf_yet", overflow_o, 0);
    feed("c4b", 1, 1'b0);
    finish_feed("c4");
    check("c4_nnz", nnz_o, 15);
    check("c4_ovf", overflow_o, 1);
    check_arrays("c4");

    // Reset after 5 accepts, with a start request held during LOAD
    load_case1();
    do_start(4, 4);
    start_i = 1'b1;
    rows_i  = 2;
    cols_i  = 2;
    feed("c5", 5, 1'b0);
    @(posedge clk_i);
    #1;
    check("c5_mid_nnz", nnz_o, 1);
    check("c5_mid_rows", rows_o, 4);
    check("c5_mid_ready", elem_ready_o, 1);
    check("c5_mid_nv0", nv[0], 1);
    elem_valid_i = 1'b0;
    start_i      = 1'b0;
    rst_ni       = 1'b0;
    #1;
    check_idle_zero("c5_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    load_case1();
    do_start(4, 4);
    feed("c6", 16, 1'b0);
    finish_feed("c6");
    check("c6_nnz", nnz_o, 7);
    check("c6_rows", rows_o, 4);
    check_arrays("c6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_encoder.md
CSR_ENCODER -- requirements
Module: csr_encoder

Interface
REQ-001 SHALL have parameter data_width_param, default 32, meaning width of one matrix element.
REQ-002 SHALL have parameter max_elements_param, default 16, meaning entries per NV/CI/RP array.
REQ-003 SHALL have parameter idx_width_param, default 4, meaning width of every index, count and dimension.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports clk_i and rst_ni.
REQ-005 clk_i  input  1  clock; all state changes on the rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 start_i  input  1  begins encoding one dense matrix.
REQ-008 rows_i  input  idx_width_param  row count, latched on start.
REQ-009 cols_i  input  idx_width_param  column count, latched on start.
REQ-010 elem_valid_i  input  1  elem_data_i is valid.
REQ-011 elem_data_i  input  data_width_param  dense element, row-major order.
REQ-012 elem_ready_o  output  1  block accepts an element this cycle.
REQ-013 NV_o  output  [0:max_elements_param-1][data_width_param]  nonzero values.
REQ-014 CI_o  output  [0:max_elements_param-1][idx_width_param]  column index of each nonzero.
REQ-015 RP_o  output  [0:max_elements_param-1][idx_width_param]  row pointers.
REQ-016 nnz_o  output  idx_width_param  nonzeros stored.
REQ-017 rows_o  output  idx_width_param  latched rows_i; drives the multiplier rows_A_i.
REQ-018 busy_o, done_o, overflow_o  output  1 each  encoding in progress, one-cycle completion pulse, capacity exceeded (sticky).

Function
REQ-019 SHALL implement states IDLE, LOAD and DONE.
REQ-020 In IDLE or DONE, start_i=1 SHALL do all of the following at that edge: zero NV/CI/RP/nnz/overflow, latch rows_i/cols_i, reset row/col counters.
REQ-021 After a start_i edge with rows_i=0 or cols_i=0, the block SHALL go to DONE with done_o=1 in the next cycle; no element is accepted.
REQ-022 After a start_i edge with rows_i and cols_i both nonzero, the block SHALL enter LOAD.
REQ-023 start_i SHALL be ignored in LOAD.
REQ-024 elem_ready_o SHALL equal 1 exactly when the state is LOAD; busy_o SHALL equal elem_ready_o.
REQ-025 An element SHALL be accepted only on an edge where elem_valid_i and elem_ready_o are both 1; elem_valid_i without elem_ready_o SHALL change nothing.
REQ-026 Capacity CAP SHALL be max_elements_param-1 (15 at defaults), so every RP value fits idx_width_param.
REQ-027 On acceptance of a nonzero element with nnz<CAP: NV[nnz]=data, CI[nnz]=current col, nnz increments; results are visible the cycle after the edge.
REQ-028 An accepted nonzero with nnz=CAP SHALL be dropped and set overflow_o=1 until the next start or reset; the row/col counters still advance.
REQ-029 Zero elements SHALL advance the counters only.
REQ-030 RP[0] SHALL be 0.
REQ-031 When the accepted element has col=cols-1: RP[row+1]=updated nnz (including this element), col wraps to 0, row increments.
REQ-032 Acceptance of element (rows-1, cols-1) SHALL move the state to DONE; done_o=1 for exactly the following cycle.
REQ-033 Latency from last acceptance to done_o SHALL be 1 cycle.
REQ-034 In DONE, all outputs SHALL hold until the next start; unused array entries SHALL remain 0.
REQ-035 A start_i in the same cycle as the done_o pulse SHALL be honoured.

Reset
REQ-036 rst_ni=0 SHALL, asynchronously and in any state including mid-LOAD, force: state IDLE; all arrays, nnz_o, rows_o and counters 0; elem_ready_o, busy_o, done_o, overflow_o 0.
REQ-037 After rst_ni rises, the block SHALL wait in IDLE for start_i.

Verification
REQ-038 4x4 dense rows {0,0,1,0},{0,5,7,0},{9,0,0,4},{2,6,0,0}, valid held high -> NV={1,5,7,9,4,2,6,0..}, CI={2,1,2,0,3,0,1,0..}, RP={0,1,3,5,7,0..}, nnz=7, rows_o=4, done_o 1 cycle after the 16th accept.
REQ-039 Same matrix with elem_valid_i toggling every other cycle -> identical arrays; done_o 1 cycle after the 16th handshake.
REQ-040 3x5 all-zero matrix -> nnz=0, all arrays 0, overflow_o=0, done_o after the 15th accept.
REQ-041 4x4 with values 1..16 -> NV={1..15}, RP={0,4,8,12,15,0..}, nnz=15, overflow_o=1.
REQ-042 rows_i=0, cols_i=4 with start -> elem_ready_o never 1, done_o=1 on the cycle after start.
REQ-043 rst_ni low after 5 accepts -> all outputs 0 immediately; a new start then encodes the 4x4 case correctly.
